// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA sync-stream timing lock and note-tube decoder
// Optional err_count/frame_count outputs: define VGA_FRAME_MONITOR_STATS_EN.

module vga_frame_monitor #(
    parameter int HPIXELS    = 800,
    parameter int VLINES     = 521,
    parameter int HPULSE     = 96,
    parameter int HBP        = 144,
    parameter int HFP        = 784,
    parameter int VBP        = 31,
    parameter int VFP        = 511,
    parameter int PROBE_LINE = 271
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        de,
    output logic        locked,
    output logic        sync_err,
    output logic [2:0]  nota,
    output logic        nota_valid,
`ifdef VGA_FRAME_MONITOR_STATS_EN
    output logic [7:0]  err_count,
    output logic [15:0] frame_count,
`endif
    output logic        color_err
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST = 10'(VLINES - 1);
    localparam logic [7:0] UNLIT  = 8'hFF;

    state_t      state_q, state_d;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [7:0]  rgb_q;
    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic [9:0]  low_q, low_d, width_q;
    logic        bad_line_q, bad_line_d, bad_col_q, bad_col_d;
    logic [2:0]  lit_q, lit_d, nota_q, nota_d;
    logic        sync_err_q, sync_err_d, nota_valid_q, nota_valid_d;
    logic        color_err_q, color_err_d;
    logic        hs_fall, hs_rise, vs_fall, bad_line, frame_good, frame_end;
    logic [2:0]  tube_sel;
    logic [7:0]  lit_rgb;
    logic        probe;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign hs_fall = !hs_q && hs_prev_q;
    assign hs_rise = hs_q && !hs_prev_q;
    assign vs_fall = !vs_q && vs_prev_q;

    // *_d counts describe the sample now held in hs_q/rgb_q; *_q lag by one.
    assign hcount_d = hs_fall ? 10'd0 : sat_inc(hcount_q);
    assign vcount_d = hs_fall ? (vs_fall ? 10'd0 : sat_inc(vcount_q)) : vcount_q;
    assign low_d    = hs_fall ? 10'd1 : (!hs_q ? sat_inc(low_q) : low_q);

    assign bad_line = (hs_fall && !(hcount_q == H_LAST && width_q == 10'(HPULSE)))
                    || (!hs_fall && hcount_q == 10'd1022);
    assign frame_good = (vcount_q == V_LAST) && !bad_line_q && !bad_line;

    always_comb begin
        tube_sel = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (hcount_d == 10'(HBP + 230 + 60 * i)) tube_sel = 3'(i + 1);
        end
    end

    always_comb begin
        case (tube_sel)
            3'd1:    lit_rgb = 8'hE0;
            3'd2:    lit_rgb = 8'h1C;
            3'd3:    lit_rgb = 8'h03;
            3'd4:    lit_rgb = 8'hFC;
            default: lit_rgb = 8'h00;
        endcase
    end

    assign probe = (vcount_d == 10'(PROBE_LINE)) && (tube_sel != 3'd0);

    // Tubes are visited left to right, so the first lit one is the lowest-numbered.
    always_comb begin
        lit_d     = lit_q;
        bad_col_d = bad_col_q;
        if (vs_fall) begin
            lit_d     = 3'd0;
            bad_col_d = 1'b0;
        end else if (probe) begin
            if (rgb_q == lit_rgb) begin
                if (lit_q == 3'd0) lit_d = tube_sel;
                else               bad_col_d = 1'b1;
            end else if (rgb_q != UNLIT) begin
                bad_col_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sync_err_d = 1'b0;
        frame_end  = 1'b0;
        bad_line_d = vs_fall ? 1'b0 : (bad_line_q | bad_line);
        case (state_q)
            SEARCH: begin
                if (vs_fall) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (bad_line) begin
                    state_d = SEARCH;
                end else if (vs_fall && frame_good) begin
                    state_d   = LOCKED;
                    frame_end = 1'b1;
                end
            end
            LOCKED: begin
                if (bad_line || (vs_fall && !frame_good)) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end else if (vs_fall) begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        nota_d       = nota_q;
        nota_valid_d = 1'b0;
        color_err_d  = color_err_q;
        if (frame_end) begin
            if (bad_col_q) begin
                color_err_d = 1'b1;
            end else begin
                nota_d       = lit_q;
                nota_valid_d = 1'b1;
                color_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            rgb_q        <= 8'd0;
            hcount_q     <= 10'd0;
            vcount_q     <= 10'd0;
            low_q        <= 10'd0;
            width_q      <= 10'd0;
            bad_line_q   <= 1'b0;
            lit_q        <= 3'd0;
            bad_col_q    <= 1'b0;
            state_q      <= SEARCH;
            sync_err_q   <= 1'b0;
            nota_q       <= 3'd0;
            nota_valid_q <= 1'b0;
            color_err_q  <= 1'b0;
        end else begin
            hs_q         <= hsync;
            vs_q         <= vsync;
            hs_prev_q    <= hs_q;
            vs_prev_q    <= vs_q;
            rgb_q        <= {red, green, blue};
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            low_q        <= low_d;
            if (hs_rise) width_q <= low_q;
            bad_line_q   <= bad_line_d;
            lit_q        <= lit_d;
            bad_col_q    <= bad_col_d;
            state_q      <= state_d;
            sync_err_q   <= sync_err_d;
            nota_q       <= nota_d;
            nota_valid_q <= nota_valid_d;
            color_err_q  <= color_err_d;
        end
    end

`ifdef VGA_FRAME_MONITOR_STATS_EN
    logic [7:0]  err_count_q;
    logic [15:0] frame_count_q;

    always_ff @(posedge dclk) begin
        if (clr) begin
            err_count_q   <= 8'd0;
            frame_count_q <= 16'd0;
        end else begin
            if (sync_err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            if (frame_end) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;
`endif

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign locked     = (state_q == LOCKED);
    assign de         = locked
                      && hcount_q >= 10'(HBP) && hcount_q < 10'(HFP)
                      && vcount_q >= 10'(VBP) && vcount_q < 10'(VFP);
    assign sync_err   = sync_err_q;
    assign nota       = nota_q;
    assign nota_valid = nota_valid_q;
    assign color_err  = color_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - randomized line-level model bench for vga_frame_monitor

module tb_vga_frame_monitor;

    localparam int HP = 420;
    localparam int VL = 8;
    localparam int HPW = 2;
    localparam int HB = 4;
    localparam int HF = 416;
    localparam int VB = 2;
    localparam int VF = 7;
    localparam int PL = 4;
    localparam int DE_FRAME = (HF - HB) * (VF - VB);

    logic        dclk = 1'b0;
    logic        clr = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [2:0]  red = 3'd0;
    logic [2:0]  green = 3'd0;
    logic [1:0]  blue = 2'd0;
    logic [9:0]  hcount, vcount;
    logic        de, locked, sync_err, nota_valid, color_err;
    logic [2:0]  nota;
`ifdef VGA_FRAME_MONITOR_STATS_EN
    logic [7:0]  err_count;
    logic [15:0] frame_count;
`endif

    vga_frame_monitor #(
        .HPIXELS(HP), .VLINES(VL), .HPULSE(HPW), .HBP(HB), .HFP(HF),
        .VBP(VB), .VFP(VF), .PROBE_LINE(PL)
    ) dut (
        .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .hcount(hcount), .vcount(vcount), .de(de), .locked(locked),
        .sync_err(sync_err), .nota(nota), .nota_valid(nota_valid),
`ifdef VGA_FRAME_MONITOR_STATS_EN
        .err_count(err_count), .frame_count(frame_count),
`endif
        .color_err(color_err)
    );

    always #20 dclk = ~dclk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: 0=search 1=acquire 2=locked, advanced once per generated line.
    int        m_state, m_vc, m_lit, m_nota, m_errs, m_frames;
    bit        m_bad, m_badcol, m_valid, m_syncerr, m_colerr;
    int        prev_len, prev_pw;
    int        de_cnt;
    bit        de_valid, all_lock, none_lock;
    logic [7:0] tubes [4];

    function automatic logic [7:0] lit_of(input int k);
        case (k)
            0: return 8'hE0;
            1: return 8'h1C;
            2: return 8'h03;
            default: return 8'hFC;
        endcase
    endfunction

    function automatic logic [7:0] pix(input int line, input int col);
        if (line == PL)
            for (int k = 0; k < 4; k++)
                if (col == HB + 230 + 60 * k) return tubes[k];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_state = 0; m_vc = 0; m_lit = 0; m_nota = 0; m_errs = 0; m_frames = 0;
        m_bad = 0; m_badcol = 0; m_valid = 0; m_syncerr = 0; m_colerr = 0;
        prev_len = 0; prev_pw = 0; de_valid = 0; de_cnt = 0;
    endtask

    task automatic model_frame_end();
        if (m_badcol) m_colerr = 1;
        else begin
            m_nota = m_lit; m_valid = 1; m_colerr = 0;
        end
        m_frames = (m_frames + 1) % 65536;
    endtask

    task automatic model_line(input int line);
        bit bad, fg;
        logic [7:0] c;
        bad = !(prev_len == HP && prev_pw == HPW);
        m_valid = 0; m_syncerr = 0;
        if (line == 0) begin
            fg = (m_vc == VL - 1) && !m_bad && !bad;
            if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (bad) m_state = 0;
                else if (fg) begin m_state = 2; model_frame_end(); end
            end else begin
                if (!fg) begin m_state = 0; m_syncerr = 1; end
                else model_frame_end();
            end
            m_bad = 0; m_lit = 0; m_badcol = 0; m_vc = 0;
        end else begin
            if (bad) begin
                m_bad = 1;
                if (m_state == 1) m_state = 0;
                else if (m_state == 2) begin m_state = 0; m_syncerr = 1; end
            end
            m_vc = (m_vc >= 1023) ? 1023 : m_vc + 1;
        end
        if (m_syncerr && m_errs < 255) m_errs++;
        if (m_vc == PL) begin
            for (int k = 0; k < 4; k++) begin
                c = pix(line, HB + 230 + 60 * k);
                if (c == lit_of(k)) begin
                    if (m_lit == 0) m_lit = k + 1;
                    else m_badcol = 1;
                end else if (c != 8'hFF) m_badcol = 1;
            end
        end
    endtask

    task automatic zero_checks();
        check_eq("rst_hcount", 32'(hcount), 0);
        check_eq("rst_vcount", 32'(vcount), 0);
        check_eq("rst_de", 32'(de), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_sync_err", 32'(sync_err), 0);
        check_eq("rst_nota", 32'(nota), 0);
        check_eq("rst_nota_valid", 32'(nota_valid), 0);
        check_eq("rst_color_err", 32'(color_err), 0);
`ifdef VGA_FRAME_MONITOR_STATS_EN
        check_eq("rst_err_count", 32'(err_count), 0);
        check_eq("rst_frame_count", 32'(frame_count), 0);
`endif
    endtask

    task automatic line_checks(input int line);
        check_eq("hcount", 32'(hcount), 0);
        check_eq("vcount", 32'(vcount), 32'(m_vc));
        check_eq("locked", 32'(locked), 32'(m_state == 2));
        check_eq("sync_err", 32'(sync_err), 32'(m_syncerr));
        check_eq("nota", 32'(nota), 32'(m_nota));
        check_eq("nota_valid", 32'(nota_valid), 32'(m_valid));
        check_eq("color_err", 32'(color_err), 32'(m_colerr));
`ifdef VGA_FRAME_MONITOR_STATS_EN
        check_eq("err_count", 32'(err_count), 32'(m_errs));
        check_eq("frame_count", 32'(frame_count), 32'(m_frames));
`endif
        if (line == 0) begin
            if (de_valid && all_lock) check_eq("de_frame", 32'(de_cnt), 32'(DE_FRAME));
            else if (de_valid && none_lock) check_eq("de_unlocked", 32'(de_cnt), 0);
            de_cnt = 0; de_valid = 1; all_lock = 1; none_lock = 1;
        end
        if (m_state == 2) none_lock = 0;
        else all_lock = 0;
    endtask

    task automatic drive_line(input int line, input int len, input int pw, input int rst_col);
        bit did_rst = 0;
        for (int col = 0; col < len; col++) begin
            @(negedge dclk);
            if (col == 2) line_checks(line);
            if (col == 3) begin
                check_eq("sync_err_width", 32'(sync_err), 0);
                check_eq("nota_valid_width", 32'(nota_valid), 0);
            end
            if (did_rst && col == rst_col + 1) begin
                zero_checks();
                model_reset();
            end
            de_cnt += int'(de);
            clr = (col == rst_col);
            if (col == rst_col) did_rst = 1;
            hsync = (col < pw) ? 1'b0 : 1'b1;
            vsync = (line < 2) ? 1'b0 : 1'b1;
            {red, green, blue} = pix(line, col);
            if (col == 0) model_line(line);
        end
        prev_len = did_rst ? 0 : len;
        prev_pw  = did_rst ? 0 : pw;
    endtask

    // fault: 0 none, 1 short line, 2 narrow hsync pulse; bad_tube forces 7/0/0 there.
    task automatic drive_frame(input int note, input int fault, input int fline,
                               input int bad_tube, input int rst_line);
        for (int k = 0; k < 4; k++) tubes[k] = 8'hFF;
        if (note > 0) tubes[note - 1] = lit_of(note - 1);
        if (bad_tube > 0) tubes[bad_tube - 1] = 8'hE0;
        for (int l = 0; l < VL; l++)
            drive_line(l,
                       (fault == 1 && l == fline) ? HP - 1 : HP,
                       (fault == 2 && l == fline) ? HPW - 1 : HPW,
                       (l == rst_line) ? 100 : -1);
    endtask

    function automatic int rnote();
        return int'($urandom_range(0, 4));
    endfunction

    initial begin
        model_reset();
        all_lock = 1; none_lock = 1;
        repeat (3) @(negedge dclk);
        zero_checks();
        clr = 1'b0;
        drive_frame(2, 0, 0, 0, -1);
        drive_frame(2, 0, 0, 0, -1);
        drive_frame(0, 0, 0, 0, -1);
        drive_frame(rnote(), 1, int'($urandom_range(1, VL - 1)), 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 2, int'($urandom_range(1, VL - 1)), 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(3, 0, 0, 0, -1);
        drive_frame(3, 0, 0, 3, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, 5);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        drive_frame(rnote(), 0, 0, 0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
